change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 148 ++++++++++++++
 tb/tb_change_dispenser.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out an owed balance as 5-unit and 1-unit coins through a hopper,
//   greedy order (all 5s first), one coin request outstanding at a time.
//
//   Ports:
//     clk        in   system clock, rising edge
//     reset      in   asynchronous active-high reset
//     close      in   end-of-transaction strobe, sampled only in IDLE
//     balance    in   [3:0] change owed, sampled with close
//     coin_ack   in   hopper acknowledge, sampled only in WAIT_ACK
//     coin5_req  out  eject one 5-unit coin
//     coin1_req  out  eject one 1-unit coin
//     busy       out  high in every state except IDLE
//     done       out  one-cycle payout-complete pulse
//     remaining  out  [3:0] change still owed
//     coin_cnt   out  [3:0] coins ejected this transaction (saturating)
//     fault      out  sticky hopper-timeout flag
//
//   Build option: define CHANGE_DISPENSER_TIMEOUT_EN to add a 16-cycle
//   ack watchdog that parks the block in FAULT until reset. Without it the
//   block waits for ack indefinitely and fault is tied low.
module change_dispenser (
  input  logic       clk,
  input  logic       reset,
  input  logic       close,
  input  logic [3:0] balance,
  input  logic       coin_ack,
  output logic       coin5_req,
  output logic       coin1_req,
  output logic       busy,
  output logic       done,
  output logic [3:0] remaining,
  output logic [3:0] coin_cnt,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_DONE,
    S_FAULT
  } state_t;

  state_t     state, state_n;
  logic [3:0] denom;
  logic [3:0] rem_after;

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  logic [3:0] wdog;
`endif

  // Denomination of the request currently outstanding; selection in ISSUE
  // guarantees it never exceeds remaining, so the subtraction cannot wrap.
  assign denom     = coin5_req ? 4'd5 : 4'd1;
  assign rem_after = remaining - denom;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  assign fault = (state == S_FAULT);
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (close) state_n = (balance != 4'd0) ? S_ISSUE : S_DONE;
      end
      S_ISSUE: state_n = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (coin_ack) begin
          state_n = (rem_after == 4'd0) ? S_DONE : S_ISSUE;
        end
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
        else if (wdog == 4'hF) begin
          state_n = S_FAULT;
        end
`endif
      end
      S_DONE: state_n = S_IDLE;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
      S_FAULT: state_n = S_FAULT;
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coin5_req <= 1'b0;
      coin1_req <= 1'b0;
      remaining <= '0;
      coin_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (close) begin
            remaining <= balance;
            coin_cnt  <= '0;
          end
        end
        S_ISSUE: begin
          if (remaining >= 4'd5) coin5_req <= 1'b1;
          else                   coin1_req <= 1'b1;
        end
        S_WAIT_ACK: begin
          if (coin_ack) begin
            coin5_req <= 1'b0;
            coin1_req <= 1'b0;
            remaining <= rem_after;
            if (coin_cnt != 4'hF) coin_cnt <= coin_cnt + 4'd1;
          end
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
          else if (wdog == 4'hF) begin
            coin5_req <= 1'b0;
            coin1_req <= 1'b0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  // Cleared in ISSUE so it starts at zero on the first WAIT_ACK cycle; the
  // 16th ack-less WAIT_ACK cycle sees 15 and trips FAULT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog <= '0;
    end else if (state == S_ISSUE) begin
      wdog <= '0;
    end else if (state == S_WAIT_ACK && !coin_ack) begin
      wdog <= wdog + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
//   Directed scenarios plus randomized payouts for change_dispenser.
//   Expected coin sequences come from the greedy rule (bal/5 fives, bal%5
//   ones); the watchdog scenario adapts to CHANGE_DISPENSER_TIMEOUT_EN.
module tb_change_dispenser;

  logic       clk;
  logic       reset;
  logic       close;
  logic [3:0] balance;
  logic       coin_ack;
  logic       coin5_req;
  logic       coin1_req;
  logic       busy;
  logic       done;
  logic [3:0] remaining;
  logic [3:0] coin_cnt;
  logic       fault;

  int tests  = 0;
  int failed = 0;

  change_dispenser dut (
    .clk       (clk),
    .reset     (reset),
    .close     (close),
    .balance   (balance),
    .coin_ack  (coin_ack),
    .coin5_req (coin5_req),
    .coin1_req (coin1_req),
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
    .coin_cnt  (coin_cnt),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Greedy payout: every 5-unit coin first, then the 1-unit remainder.
  function automatic void greedy(input int bal, output int coins[$]);
    coins = {};
    for (int i = 0; i < bal / 5; i++) coins.push_back(5);
    for (int i = 0; i < bal % 5; i++) coins.push_back(1);
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_req5"},  32'(coin5_req), 0);
    chk({tag, "_req1"},  32'(coin1_req), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_rem"},   32'(remaining), 0);
    chk({tag, "_cnt"},   32'(coin_cnt), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
  endtask

  // Payout with random ack delay per coin; optional noise pulses close
  // while busy, which must be ignored.
  task automatic pay(input int bal, input int maxd, input bit noise);
    int coins[$];
    int mrem, mcnt, d, w;
    greedy(bal, coins);
    chk("pre_busy", 32'(busy), 0);
    close = 1'b1; balance = 4'(bal);
    @(negedge clk);
    close = 1'b0; balance = 4'($urandom);
    mrem = bal; mcnt = 0;
    chk("load_rem", 32'(remaining), 32'(bal));
    chk("load_cnt", 32'(coin_cnt), 0);
    if (coins.size() == 0) begin
      chk("zero_done", 32'(done), 1);
      chk("zero_reqs", 32'(coin5_req | coin1_req), 0);
      @(negedge clk);
      chk("zero_done_end", 32'(done), 0);
      chk("zero_busy_end", 32'(busy), 0);
      return;
    end
    chk("issue_busy", 32'(busy), 1);
    for (int k = 0; k < coins.size(); k++) begin
      w = 0;
      while (!(coin5_req | coin1_req) && w < 4) begin
        @(negedge clk);
        w++;
      end
      chk("req_seen", 32'(coin5_req | coin1_req), 1);
      chk("req5", 32'(coin5_req), 32'(coins[k] == 5));
      chk("req1", 32'(coin1_req), 32'(coins[k] == 1));
      chk("rem_before", 32'(remaining), 32'(mrem));
      d = $urandom_range(0, maxd);
      for (int j = 0; j < d; j++) begin
        if (noise) begin
          close = 1'b1; balance = 4'($urandom);
        end
        @(negedge clk);
        close = 1'b0;
        chk("hold5", 32'(coin5_req), 32'(coins[k] == 5));
        chk("hold1", 32'(coin1_req), 32'(coins[k] == 1));
        chk("hold_rem", 32'(remaining), 32'(mrem));
      end
      coin_ack = 1'b1;
      @(negedge clk);
      coin_ack = 1'b0;
      mrem = mrem - coins[k];
      mcnt = (mcnt < 15) ? mcnt + 1 : 15;
      chk("ack_reqs", 32'(coin5_req | coin1_req), 0);
      chk("ack_rem", 32'(remaining), 32'(mrem));
      chk("ack_cnt", 32'(coin_cnt), 32'(mcnt));
      chk("ack_done", 32'(done), 32'(k == coins.size() - 1));
      chk("ack_busy", 32'(busy), 1);
    end
    @(negedge clk);
    chk("end_done", 32'(done), 0);
    chk("end_busy", 32'(busy), 0);
    chk("end_cnt", 32'(coin_cnt), 32'(mcnt));
  endtask

  // Payout with coin_ack held high: each coin costs exactly two cycles.
  task automatic held(input int bal);
    int coins[$];
    int seen[$];
    int cyc;
    greedy(bal, coins);
    seen = {};
    coin_ack = 1'b1; close = 1'b1; balance = 4'(bal);
    @(negedge clk);
    close = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      if (coin5_req) seen.push_back(5);
      if (coin1_req) seen.push_back(1);
      @(negedge clk);
      cyc++;
    end
    chk("held_latency", 32'(cyc), 32'(2 * coins.size() + 1));
    chk("held_ncoins", 32'(seen.size()), 32'(coins.size()));
    for (int k = 0; k < coins.size() && k < seen.size(); k++)
      chk("held_coin", 32'(seen[k]), 32'(coins[k]));
    chk("held_rem", 32'(remaining), 0);
    chk("held_cnt", 32'(coin_cnt), 32'(coins.size()));
    coin_ack = 1'b0;
    @(negedge clk);
    chk("held_done_end", 32'(done), 0);
    chk("held_busy_end", 32'(busy), 0);
  endtask

  initial begin
    int w, hi;
    reset = 1'b1; close = 1'b0; balance = '0; coin_ack = 1'b0;
    #3;
    chk_idle_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 7 with ack held: 5,1,1 and done on the 7th cycle
    held(7);
    // zero balance: immediate done
    pay(0, 0, 1'b0);
    // 10 with a 3-cycle ack delay per coin
    pay(10, 3, 1'b0);
    // stray ack while idle leaves the finished transaction untouched
    coin_ack = 1'b1;
    repeat (3) @(negedge clk);
    coin_ack = 1'b0;
    chk("stray_busy", 32'(busy), 0);
    chk("stray_reqs", 32'(coin5_req | coin1_req), 0);
    chk("stray_rem", 32'(remaining), 0);
    chk("stray_cnt", 32'(coin_cnt), 2);
    // 6 with close pulses while busy
    pay(6, 2, 1'b1);

    // 9, reset after the first ack while the 1-coin request is up
    close = 1'b1; balance = 4'd9;
    @(negedge clk);
    close = 1'b0;
    w = 0;
    while (!coin5_req && w < 4) begin @(negedge clk); w++; end
    chk("rst_req5", 32'(coin5_req), 1);
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    chk("rst_rem_after_ack", 32'(remaining), 4);
    chk("rst_cnt_after_ack", 32'(coin_cnt), 1);
    @(posedge clk);
    #2;
    chk("rst_req1_up", 32'(coin1_req), 1);
    reset = 1'b1;
    #1;
    chk_idle_zero("async_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_reqs", 32'(coin5_req | coin1_req), 0);
    chk("post_rst_busy", 32'(busy), 0);
    pay(3, 1, 1'b0);

    // 4 with no ack ever
    close = 1'b1; balance = 4'd4;
    @(negedge clk);
    close = 1'b0;
    w = 0;
    while (!coin1_req && w < 4) begin @(negedge clk); w++; end
    chk("wd_req1", 32'(coin1_req), 1);
    hi = 0;
    while (coin1_req && hi < 40) begin hi++; @(negedge clk); end
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    chk("wd_hi_cycles", 32'(hi), 16);
    chk("wd_fault", 32'(fault), 1);
    chk("wd_reqs", 32'(coin5_req | coin1_req), 0);
    chk("wd_rem", 32'(remaining), 4);
    chk("wd_busy", 32'(busy), 1);
    close = 1'b1; coin_ack = 1'b1; balance = 4'd2;
    repeat (3) @(negedge clk);
    close = 1'b0; coin_ack = 1'b0;
    chk("wd_sticky_fault", 32'(fault), 1);
    chk("wd_sticky_busy", 32'(busy), 1);
    chk("wd_sticky_rem", 32'(remaining), 4);
`else
    chk("wd_hi_cycles", 32'(hi), 40);
    chk("wd_fault", 32'(fault), 0);
    chk("wd_req_held", 32'(coin1_req), 1);
    chk("wd_rem", 32'(remaining), 4);
`endif
    reset = 1'b1;
    #1;
    chk_idle_zero("wd_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 24; i++)
      pay($urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++)
      held($urandom_range(0, 15));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
